// File: rtl/sig_namea_reader.sv
// Reassembles the 224-bit SIG_NAMEA word from a 96-bit upper and a 128-bit lower slice,
// buffers whole words in a small FIFO and streams each one out LSB-first as BEAT_W-bit beats.
`timescale 1ns/1ps

module sig_namea_reader #(
  parameter int BEAT_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hi_valid,
  input  logic [95:0]       hi_data,
  output logic              hi_ready,
  input  logic              lo_valid,
  input  logic [127:0]      lo_data,
  output logic              lo_ready,
  output logic              out_valid,
  output logic [BEAT_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [7:0]        word_cnt
);

  localparam int WORD_W = 224;
  localparam int NBEATS = WORD_W / BEAT_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBEATS - 1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [95:0]       hi_q;
  logic [127:0]      lo_q;
  logic              hi_full;
  logic              lo_full;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic [IDX_W-1:0]  beat_idx;

  logic hi_take;
  logic lo_take;
  logic push;
  logic fire;
  logic pop;

  // A slice register is only refilled once it reads empty, so a push edge can never also accept.
  assign hi_take = hi_valid & ~hi_full;
  assign lo_take = lo_valid & ~lo_full;
  assign push    = hi_full & lo_full & (count < DEPTH_CNT);
  assign fire    = out_valid & out_ready;
  assign pop     = fire & (beat_idx == LAST_IDX);

  assign hi_ready  = ~hi_full;
  assign lo_ready  = ~lo_full;
  assign out_valid = (count != '0);
  assign out_last  = out_valid & (beat_idx == LAST_IDX);
  assign out_data  = mem[rd_ptr][beat_idx * BEAT_W +: BEAT_W];

  // NOTE: slice and FIFO storage carry no reset; the full flags and count gate every read,
  // so stale contents after reset are never observed and the arrays stay plain RAM.
  always_ff @(posedge clk) begin
    if (hi_take) hi_q <= hi_data;
    if (lo_take) lo_q <= lo_data;
    if (push)    mem[wr_ptr] <= {hi_q, lo_q};
  end

  // NOTE: every register here updates with <= so all reads in this edge see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_full <= 1'b0;
      lo_full <= 1'b0;
    end else begin
      if (push)         hi_full <= 1'b0;
      else if (hi_take) hi_full <= 1'b1;
      if (push)         lo_full <= 1'b0;
      else if (lo_take) lo_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx <= '0;
      word_cnt <= '0;
    end else if (fire) begin
      if (beat_idx == LAST_IDX) begin
        beat_idx <= '0;
        word_cnt <= word_cnt + 8'd1;
      end else begin
        beat_idx <= beat_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sig_namea_reader.sv
// Directed self-checking bench for sig_namea_reader: latency, split arrival, back-pressure,
// random stalls, asynchronous reset mid-word and word-counter wrap.
`timescale 1ns/1ps

module tb_sig_namea_reader;

  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hi_valid;
  logic [95:0]   hi_data;
  logic          hi_ready;
  logic          lo_valid;
  logic [127:0]  lo_data;
  logic          lo_ready;
  logic          out_valid;
  logic [BW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic [7:0]    word_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  sig_namea_reader #(.BEAT_W(BW), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hi_valid  (hi_valid),
    .hi_data   (hi_data),
    .hi_ready  (hi_ready),
    .lo_valid  (lo_valid),
    .lo_data   (lo_data),
    .lo_ready  (lo_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [95:0] h, input logic [127:0] l);
    logic hs, ls;
    hi_data  = h;
    lo_data  = l;
    hi_valid = 1'b1;
    lo_valid = 1'b1;
    for (int c = 0; c < 400 && (hi_valid || lo_valid); c++) begin
      hs = hi_valid & hi_ready;
      ls = lo_valid & lo_ready;
      tick();
      if (hs) hi_valid = 1'b0;
      if (ls) lo_valid = 1'b0;
    end
    if (hi_valid || lo_valid) begin
      check("send_timeout", 0, 1);
      hi_valid = 1'b0;
      lo_valid = 1'b0;
    end
  endtask

  // Accept beats 0..n-1 of word w with out_ready held high.
  task automatic recv_word(input logic [223:0] w, input int n);
    out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      int c = 0;
      while (!out_valid && c < 50) begin
        tick();
        c++;
      end
      if (!out_valid) check("recv_timeout", 0, 1);
      check("beat", out_data, w[k*BW +: BW]);
      check("last", out_last, (k == 6));
      tick();
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  logic [31:0]  tbl34 [7] = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h0, 32'h0, 32'h0};
  logic [223:0] wq [4];
  logic [223:0] w;
  logic [BW:0]  held;
  logic [7:0]   wc0;
  logic         stalled;
  int           beats;
  int           last_cnt;

  initial begin
    rst_n     = 1'b0;
    hi_valid  = 1'b0;
    lo_valid  = 1'b0;
    hi_data   = '0;
    lo_data   = '0;
    out_ready = 1'b0;

    // Reset state before any clock edge.
    #3;
    check("rst_hi_ready", hi_ready, 1);
    check("rst_lo_ready", lo_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_word_cnt", word_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Both slices in one cycle; latency and beat order of the reference word.
    out_ready = 1'b1;
    hi_data   = 96'h0;
    lo_data   = 128'h3_00000002_00000001_00000000;
    hi_valid  = 1'b1;
    lo_valid  = 1'b1;
    tick();
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    check("lat_valid_n", out_valid, 0);
    check("lat_hi_ready_n", hi_ready, 0);
    tick();
    check("lat_valid_n1", out_valid, 1);
    for (int k = 0; k < 7; k++) begin
      check("ref_beat", out_data, tbl34[k]);
      check("ref_last", out_last, (k == 6));
      tick();
    end
    check("ref_word_cnt", word_cnt, 1);
    check("ref_drained", out_valid, 0);

    // Upper slice at cycle 0, lower slice at cycle 5.
    w = {32'h66666666, 32'h55555555, 32'h44444444,
         32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    hi_data  = w[223:128];
    hi_valid = 1'b1;
    tick();
    hi_valid = 1'b0;
    for (int c = 1; c < 5; c++) begin
      check("split_hi_ready", hi_ready, 0);
      check("split_no_out", out_valid, 0);
      tick();
    end
    lo_data  = w[127:0];
    lo_valid = 1'b1;
    check("split_hi_ready5", hi_ready, 0);
    tick();
    lo_valid = 1'b0;
    check("split_no_out6", out_valid, 0);
    tick();
    check("split_out", out_valid, 1);
    recv_word(w, 7);
    check("split_word_cnt", word_cnt, 2);

    // Back-pressure: two words buffered, third held in the slice registers.
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      wq[j] = {7{8'(8'hA0 + j), 8'(j), 16'h5A5A}} ^ {224'(j) << 100};
      send_word(wq[j][223:128], wq[j][127:0]);
    end
    tick();
    tick();
    check("bp_hi_ready", hi_ready, 0);
    check("bp_lo_ready", lo_ready, 0);
    check("bp_valid", out_valid, 1);
    w = wq[0];
    check("bp_head", out_data, w[BW-1:0]);
    check("bp_last", out_last, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      w = wq[i / 7];
      check("bp_nobubble", out_valid, 1);
      check("bp_beat", out_data, w[(i % 7)*BW +: BW]);
      check("bp_beat_last", out_last, ((i % 7) == 6));
      tick();
    end
    check("bp_drained", out_valid, 0);
    check("bp_word_cnt", word_cnt, 5);

    // Random out_ready: stall stability, integrity and word-count delta.
    for (int j = 0; j < 4; j++)
      wq[j] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    wc0      = word_cnt;
    beats    = 0;
    last_cnt = 0;
    stalled  = 1'b0;
    fork
      begin
        for (int j = 0; j < 4; j++) send_word(wq[j][223:128], wq[j][127:0]);
      end
      begin
        for (int c = 0; c < 600 && beats < 28; c++) begin
          out_ready = 1'($urandom_range(0, 1));
          if (stalled && out_valid) check("stall_hold", {out_last, out_data}, held);
          if (out_valid && out_ready) begin
            w = wq[beats / 7];
            check("rand_beat", out_data, w[(beats % 7)*BW +: BW]);
            check("rand_last", out_last, ((beats % 7) == 6));
            if (out_last) last_cnt++;
            beats++;
            stalled = 1'b0;
          end else if (out_valid) begin
            stalled = 1'b1;
            held    = {out_last, out_data};
          end else begin
            stalled = 1'b0;
          end
          tick();
        end
      end
    join
    check("rand_beats", beats, 28);
    check("rand_lasts", last_cnt, 4);
    check("rand_cnt_delta", 8'(word_cnt - wc0), 8'(last_cnt));

    // Asynchronous reset after beat 3, with a stray upper slice held.
    w = {7{32'hC0DE0000}} ^ {224'h1234_5678};
    send_word(w[223:128], w[127:0]);
    recv_word(w, 4);
    hi_data  = 96'hDEAD;
    hi_valid = 1'b1;
    tick();
    hi_valid = 1'b0;
    check("pre_rst_hi_held", hi_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hi_ready", hi_ready, 1);
    check("arst_lo_ready", lo_ready, 1);
    check("arst_valid", out_valid, 0);
    check("arst_last", out_last, 0);
    check("arst_word_cnt", word_cnt, 0);
    tick();
    rst_n = 1'b1;
    w = {32'h77, 32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    send_word(w[223:128], w[127:0]);
    check("post_rst_cnt0", word_cnt, 0);
    recv_word(w, 7);
    check("post_rst_cnt1", word_cnt, 1);

    // 257 words: counter wraps 255 -> 0 and ends at 1.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      w = {7{32'(i)}};
      send_word(w[223:128], w[127:0]);
      recv_word(w, 7);
      if (i == 254) check("wrap_255", word_cnt, 255);
      if (i == 255) check("wrap_0", word_cnt, 0);
    end
    check("wrap_end", word_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
